grayscale_histogram: RTL and testbench
======================================

Name: grayscale_histogram

Overview:
Streaming per-frame luminance histogram. It sits directly downstream of the combinational RGB-to-grayscale converter and consumes its 8-bit grayscale output, one pixel per handshake. It accumulates a count per gray level over one frame, then streams all 256 bin counts out in order for auto-exposure and contrast logic. Bins are cleared as they are read out, so back-to-back frames need no extra clear pass.

Parameters:
PIXEL_WIDTH, 8, grayscale width; bin count NUM_BINS = 2**PIXEL_WIDTH
COUNT_WIDTH, 20, width of each bin counter; counts saturate at all-ones

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  asynchronous, active-low reset
s_gray  in  PIXEL_WIDTH  grayscale pixel from rgb_to_grayscale
s_valid  in  1  s_gray valid
s_ready  out  1  block accepts pixel this cycle
s_last  in  1  qualifies final pixel of frame
m_bin  out  PIXEL_WIDTH  bin index of current output beat
m_count  out  COUNT_WIDTH  count of bin m_bin
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts beat
m_last  out  1  high on bin NUM_BINS-1 beat
busy  out  1  high in any state other than ACCUM

Behaviour:
- Reset (resetn low, asynchronous): state=CLEAR, clear address=0, s_ready=0, m_valid=0, m_last=0, m_bin=0, m_count=0, busy=1. RAM contents are not reset; the CLEAR state zeroes them.
- Transfer rule: a pixel is accepted when s_valid&&s_ready. An output beat completes when m_valid&&m_ready.
- CLEAR: writes 0 to address 0..NUM_BINS-1, one per cycle. This takes NUM_BINS cycles with s_ready=0, then the block moves to ACCUM. CLEAR is entered only after reset.
- ACCUM: s_ready=1 and busy=0.
  - Read-modify-write pipeline. Cycle N: read RAM[s_gray]. Cycle N+1: write the incremented value.
  - Full throughput at one pixel per cycle.
  - Same-bin hazard: if the pixel in cycle N+1 hits the bin being written in cycle N+1, the pipeline forwards the write value instead of the stale RAM read. Runs like {7,7,7,7} must count 4.
  - Saturation: a count of all-ones stays all-ones; it does not wrap.
  - Accepting a pixel with s_last=1 moves the block to FLUSH. s_ready drops in the next cycle.
- FLUSH: one cycle with s_ready=0. The final write retires, then the read of bin 0 is issued. Next state is READOUT.
- READOUT:
  - Beats for bins 0..NUM_BINS-1 go out strictly in order, with m_last=1 only on the last bin.
  - m_bin, m_count and m_last are registered. They hold stable while m_valid&&!m_ready.
  - On each beat handshake, that bin is written to 0 and the next bin is prefetched. With m_ready held high, there are no bubbles: one beat per cycle.
  - The handshake on the last bin sets m_valid=0 and moves the block to ACCUM in the next cycle.
  - s_ready=0 throughout.
- Empty frame: a single pixel with s_last produces a histogram holding only that pixel.
- s_last while s_ready=0 has no effect, because no transfer occurs.
- Reset asserted mid-frame or mid-readout aborts immediately. Outputs go to their reset values and a full CLEAR follows; partial data is discarded.
- Invariant: the sum of m_count over one readout equals the number of pixels accepted in that frame, provided no bin saturated.

Decomposition:
- Package grayscale_pkg:
  - PIXEL_WIDTH and NUM_BINS constants
  - typedef gray_t (logic [PIXEL_WIDTH-1:0])
  - enum hist_state_t {CLEAR, ACCUM, FLUSH, READOUT}
  - shared with rgb_to_grayscale's output width
- Sub-module histogram_ram:
  - simple dual-port RAM, NUM_BINS x COUNT_WIDTH
  - one write port, one read port, 1-cycle registered read, no reset
  - infers BRAM; forwarding logic stays in the parent

Test Plan:
- Release reset: s_ready stays 0 for exactly 256 cycles, then 1. m_valid stays 0 and busy falls when s_ready rises.
- Back-to-back frame {10,10,10,200} with s_last on the 4th pixel, m_ready=1: expect 256 consecutive beats, bin10=3, bin200=1, all others 0, m_last only at m_bin=255.
- Second frame {10} right after the first readout: bin10=1 and all others 0. This proves clear-on-read with no CLEAR pass.
- Chain rgb_to_grayscale in front with r=g=b=100 for 5 pixels (gray=(2700+9200+900+64)>>7=100): bin100=5.
- m_ready toggling randomly during readout: m_bin and m_count are stable while stalled, no beat is dropped or duplicated, and the order is still 0..255.
- COUNT_WIDTH=4, 20 pixels of value 0: bin0=15 (saturated). Then assert resetn low at bin 3 of the readout: outputs return to 0 asynchronously, 256 cycles of CLEAR follow, and the next frame {5} gives bin5=1.

Source files
------------

// File: rtl/grayscale_pkg.sv
// Shared grayscale definitions: pixel width, bin count and histogram FSM states.
package grayscale_pkg;
  localparam int PIXEL_WIDTH = 8;
  localparam int NUM_BINS    = 2**PIXEL_WIDTH;

  typedef logic [PIXEL_WIDTH-1:0] gray_t;

  typedef enum logic [1:0] {
    CLEAR,
    ACCUM,
    FLUSH,
    READOUT
  } hist_state_t;
endpackage

// File: rtl/histogram_ram.sv
// Simple dual-port bin storage: one write port, one read port with a registered read.
module histogram_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read-during-write to the same address returns the old contents.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/grayscale_histogram.sv
// Per-frame gray-level histogram: accumulate one pixel per cycle, then stream and clear all bins.
module grayscale_histogram #(
  parameter int PIXEL_WIDTH = grayscale_pkg::PIXEL_WIDTH,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [PIXEL_WIDTH-1:0] s_gray,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  output logic [PIXEL_WIDTH-1:0] m_bin,
  output logic [COUNT_WIDTH-1:0] m_count,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy
);
  import grayscale_pkg::*;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [PIXEL_WIDTH-1:0] LAST_BIN = '1;

  hist_state_t r_state, w_state_next;
  logic [PIXEL_WIDTH-1:0] r_clr_addr;
  logic                   r_p1_valid;
  logic [PIXEL_WIDTH-1:0] r_p1_bin;
  logic                   r_fwd_hit;
  logic [COUNT_WIDTH-1:0] r_fwd_data;
  logic [PIXEL_WIDTH-1:0] r_pf_bin;
  logic                   r_pf_done;
  logic                   r_m_valid, r_m_last;
  logic [PIXEL_WIDTH-1:0] r_m_bin;
  logic [COUNT_WIDTH-1:0] r_m_count;

  logic                   w_accept, w_load, w_beat, w_we;
  logic [PIXEL_WIDTH-1:0] w_waddr, w_raddr;
  logic [COUNT_WIDTH-1:0] w_wdata, w_rdata, w_base;

  histogram_ram #(.ADDR_WIDTH(PIXEL_WIDTH), .DATA_WIDTH(COUNT_WIDTH)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_accept = s_valid && (r_state == ACCUM);
  assign w_beat   = r_m_valid && m_ready;
  assign w_load   = (r_state == READOUT) && !r_pf_done && (!r_m_valid || m_ready);
  // A write landing in the same cycle as a read of that bin is invisible to the RAM read.
  assign w_base   = r_fwd_hit ? r_fwd_data : w_rdata;

  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_waddr      = r_clr_addr;
    w_wdata      = '0;
    w_raddr      = s_gray;
    case (r_state)
      CLEAR: begin
        w_we = 1'b1;
        if (r_clr_addr == LAST_BIN) w_state_next = ACCUM;
      end
      ACCUM: begin
        if (w_accept && s_last) w_state_next = FLUSH;
      end
      FLUSH: begin
        w_raddr      = '0;
        w_state_next = READOUT;
      end
      READOUT: begin
        w_raddr = w_load ? r_pf_bin + 1'b1 : r_pf_bin;
        if (w_load) begin
          w_we    = 1'b1;
          w_waddr = r_pf_bin;
          w_wdata = '0;
        end
        if (w_beat && r_m_last) w_state_next = ACCUM;
      end
      default: w_state_next = CLEAR;
    endcase
    // Accumulate write-back; only active in ACCUM and FLUSH, never overlaps readout clears.
    if (r_p1_valid) begin
      w_we    = 1'b1;
      w_waddr = r_p1_bin;
      w_wdata = (w_base == CNT_MAX) ? w_base : w_base + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_p1_valid <= 1'b0;
      r_p1_bin   <= '0;
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
      r_pf_bin   <= '0;
      r_pf_done  <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_bin    <= '0;
      r_m_count  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_p1_valid <= w_accept;
      r_p1_bin   <= s_gray;
      r_fwd_hit  <= w_we && (w_waddr == w_raddr);
      r_fwd_data <= w_wdata;
      if (r_state == CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
      if (r_state == FLUSH) begin
        r_pf_bin  <= '0;
        r_pf_done <= 1'b0;
      end
      if (w_load) begin
        r_pf_bin  <= r_pf_bin + 1'b1;
        r_pf_done <= (r_pf_bin == LAST_BIN);
        r_m_valid <= 1'b1;
        r_m_bin   <= r_pf_bin;
        r_m_count <= w_base;
        r_m_last  <= (r_pf_bin == LAST_BIN);
      end else if (w_beat) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

  assign s_ready = (r_state == ACCUM);
  assign busy    = (r_state != ACCUM);
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign m_bin   = r_m_bin;
  assign m_count = r_m_count;
endmodule

// File: tb/tb_grayscale_histogram.sv
// Directed bench for grayscale_histogram, built with 4-bit counters to reach saturation quickly.
module tb_grayscale_histogram;
  localparam int PW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [PW-1:0] s_gray = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [PW-1:0] m_bin;
  logic [CW-1:0] m_count;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int exp_h [256];
  int got_h [256];
  logic [PW-1:0] px_q [$];

  always #5 clk = ~clk;

  grayscale_histogram #(.PIXEL_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_gray  (s_gray),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .m_bin   (m_bin),
    .m_count (m_count),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy)
  );

  task automatic check_val(input string tag, input int got, input int exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp_v);
    end
  endtask

  function automatic int gray_of(input int r, input int g, input int b);
    return (27 * r + 92 * g + 9 * b + 64) >> 7;
  endfunction

  // Counts rising edges after reset release until s_ready appears.
  task automatic wait_clear();
    int cnt = 0;
    int vseen = 0;
    while (!s_ready && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (m_valid) vseen = 1;
      if (cnt == 250) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
    end
    check_val("clear_cycles", cnt, 256);
    check_val("clear_mvalid", vseen, 0);
    check_val("busy_after_clear", busy, 0);
    for (int i = 0; i < 256; i++) exp_h[i] = 0;
    $display("clear done after %0d cycles", cnt);
  endtask

  task automatic send_frame(input string name);
    int w = 0;
    for (int i = 0; i < 256; i++) exp_h[i] = 0;
    while (!s_ready && w < 600) begin
      @(negedge clk);
      w++;
    end
    check_val("ready_wait", s_ready, 1);
    for (int i = 0; i < px_q.size(); i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_gray  = px_q[i];
      s_last  = (i == px_q.size() - 1);
      if (exp_h[int'(px_q[i])] < 15) exp_h[int'(px_q[i])]++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_gray  = '0;
    check_val("s_ready_drop", s_ready, 0);
    $display("frame %s sent: %0d pixels", name, px_q.size());
  endtask

  // mode 0: m_ready always high; mode 1: random m_ready. abort_bin >= 0 pulls reset at that beat.
  task automatic readout(input int mode, input int abort_bin);
    int idx = 0;
    int cyc = 0;
    int first = -1;
    int sum = 0;
    int stalled = 0;
    int sbin = 0;
    int scnt = 0;
    for (int i = 0; i < 256; i++) got_h[i] = -1;
    while (idx < 256 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (abort_bin >= 0 && m_valid && int'(m_bin) == abort_bin) begin
        resetn = 1'b0;
        #1;
        check_val("abort_mvalid", m_valid, 0);
        check_val("abort_mbin", m_bin, 0);
        check_val("abort_mcount", m_count, 0);
        check_val("abort_mlast", m_last, 0);
        check_val("abort_sready", s_ready, 0);
        check_val("abort_busy", busy, 1);
        $display("readout aborted at bin %0d", abort_bin);
        return;
      end
      if (stalled != 0) begin
        check_val("stall_valid", m_valid, 1);
        check_val("stall_bin", m_bin, sbin);
        check_val("stall_count", m_count, scnt);
      end
      m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      stalled = 0;
      if (m_valid) begin
        if (first < 0) first = cyc;
        if (m_ready) begin
          check_val("beat_bin", m_bin, idx);
          check_val("beat_count", m_count, exp_h[idx]);
          check_val("beat_last", m_last, (idx == 255) ? 1 : 0);
          got_h[idx] = m_count;
          sum += m_count;
          idx++;
        end else begin
          stalled = 1;
          sbin    = m_bin;
          scnt    = m_count;
        end
      end
    end
    check_val("beats", idx, 256);
    if (mode == 0) check_val("no_bubbles", cyc - first + 1, 256);
    check_val("sum", sum, px_q.size());
    @(negedge clk);
    m_ready = 1'b0;
    check_val("end_mvalid", m_valid, 0);
    check_val("end_sready", s_ready, 1);
    $display("readout done: beats=%0d sum=%0d cycles=%0d", idx, sum, cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_sready", s_ready, 0);
    check_val("rst_mvalid", m_valid, 0);
    check_val("rst_mlast", m_last, 0);
    check_val("rst_mbin", m_bin, 0);
    check_val("rst_mcount", m_count, 0);
    check_val("rst_busy", busy, 1);
    // Pixel offered with s_last during CLEAR must be ignored.
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_gray  = 8'd9;
    resetn  = 1'b1;
    wait_clear();

    px_q = {8'd10, 8'd10, 8'd10, 8'd200};
    send_frame("f1");
    readout(0, -1);
    check_val("f1_bin10", got_h[10], 3);
    check_val("f1_bin200", got_h[200], 1);
    check_val("f1_bin9", got_h[9], 0);

    px_q = {8'd10};
    send_frame("f2");
    readout(0, -1);
    check_val("f2_bin10", got_h[10], 1);
    check_val("f2_bin200", got_h[200], 0);

    px_q.delete();
    for (int i = 0; i < 5; i++) px_q.push_back(8'(gray_of(100, 100, 100)));
    send_frame("rgb100");
    readout(0, -1);
    check_val("rgb_bin100", got_h[100], 5);

    px_q = {8'd7, 8'd7, 8'd7, 8'd7, 8'd3, 8'd7, 8'd3};
    send_frame("hazard");
    readout(0, -1);
    check_val("hz_bin7", got_h[7], 5);
    check_val("hz_bin3", got_h[3], 2);

    px_q = {8'd0, 8'd255, 8'd128, 8'd0};
    send_frame("stall");
    readout(1, -1);
    check_val("st_bin0", got_h[0], 2);
    check_val("st_bin255", got_h[255], 1);
    check_val("st_bin128", got_h[128], 1);

    px_q.delete();
    for (int i = 0; i < 20; i++) px_q.push_back(8'd0);
    send_frame("sat");
    readout(0, 3);
    check_val("sat_bin0", got_h[0], 15);
    check_val("sat_bin1", got_h[1], 0);
    @(negedge clk);
    resetn = 1'b1;
    wait_clear();

    px_q = {8'd5};
    send_frame("post_reset");
    readout(0, -1);
    check_val("pr_bin5", got_h[5], 1);
    check_val("pr_bin0", got_h[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
